microcode_loader: RTL

Writer-side companion to the microcode store's 1R1W SRAM. It accepts a byte stream over a valid/ready handshake, for example from a UART receiver. It assembles the bytes MSB-first into DATA_WIDTH-bit microcode words and drives the SRAM write port (wr_enable/wr_addr/wr_data) at consecutive addresses starting from 0. While a load is in progress it asserts busy, which holds the sequencer in reset, and it reports a running byte checksum for host verification.

---
 rtl/microcode_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/microcode_loader.sv
// Byte-stream loader for the microcode SRAM: packs bytes MSB-first into words and
// writes them at consecutive addresses from 0, reporting busy/done and a byte checksum.
module microcode_loader #(
   parameter int unsigned DATA_WIDTH     = 46,  // must exceed 8
   parameter int unsigned SIZE           = 1024,
   parameter int unsigned ADDR_WIDTH     = $clog2(SIZE),
   parameter int unsigned BYTES_PER_WORD = (DATA_WIDTH + 7) / 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH:0]   i_word_count,
   input  logic                  i_in_valid,
   input  logic [7:0]            i_in_data,
   output logic                  o_in_ready,
   output logic                  o_wr_enable,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [DATA_WIDTH-1:0] o_wr_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [7:0]            o_checksum
);

   localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD + 1);
   localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(SIZE);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

   typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

   state_e                r_state;
   logic [ADDR_WIDTH:0]   r_words_left;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [CNT_W-1:0]      r_byte_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [7:0]            r_checksum;
   logic                  r_in_ready;
   logic                  r_wr_enable;
   logic                  r_busy;
   logic                  r_done;
   logic [ADDR_WIDTH:0]   w_clamped;

   // Clamping here is what keeps the address from ever wrapping past SIZE-1.
   assign w_clamped = (i_word_count > SIZE_W) ? SIZE_W : i_word_count;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state      <= StIdle;
         r_words_left <= '0;
         r_addr       <= '0;
         r_byte_cnt   <= '0;
         r_shift      <= '0;
         r_checksum   <= '0;
         r_in_ready   <= 1'b0;
         r_wr_enable  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_wr_enable <= 1'b0;
         r_done      <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_words_left <= w_clamped;
                  r_addr       <= '0;
                  r_byte_cnt   <= '0;
                  r_checksum   <= '0;
                  r_busy       <= 1'b1;
                  if (w_clamped == '0) begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= StRecv;
                     r_in_ready <= 1'b1;
                  end
               end
            end
            StRecv: begin
               if (i_in_valid && r_in_ready) begin
                  // Bytes above DATA_WIDTH fall off the top of the shift register.
                  r_shift    <= {r_shift[DATA_WIDTH-9:0], i_in_data};
                  r_checksum <= r_checksum + i_in_data;
                  r_byte_cnt <= r_byte_cnt + 1'b1;
                  if (r_byte_cnt == LAST_BYTE) begin
                     r_state     <= StWrite;
                     r_in_ready  <= 1'b0;
                     r_wr_enable <= 1'b1;
                  end
               end
            end
            StWrite: begin
               r_addr       <= r_addr + 1'b1;
               r_words_left <= r_words_left - 1'b1;
               r_byte_cnt   <= '0;
               if (r_words_left == (ADDR_WIDTH + 1)'(1)) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
               end else begin
                  r_state    <= StRecv;
                  r_in_ready <= 1'b1;
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_wr_enable = r_wr_enable;
   assign o_wr_addr   = r_addr;
   assign o_wr_data   = r_shift;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_checksum  = r_checksum;

endmodule
